// File: rtl/fir_seq.sv
// Sequencer for a symmetric FIR: sample intake, delay-line/ROM addressing, MAC strobes, result handshake.
// Define FIR_SEQ_PREADD_EN for symmetric pair mode; the default build runs single-sample over all taps.
module fir_seq #(
   parameter int unsigned WIDTH_DATA = 8,
   parameter int unsigned N_TAPS     = 16,
   localparam int unsigned A         = $clog2(N_TAPS),
   localparam int unsigned C         = $clog2(N_TAPS / 2)
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  in_valid,
   input  logic [WIDTH_DATA-1:0] sample_in,
   output logic                  in_ready,
   output logic                  we,
   output logic [A-1:0]          wr_ptr,
   output logic [WIDTH_DATA-1:0] sample_out,
   output logic [C-1:0]          coef_add,
   output logic [A-1:0]          rd_add_a,
   output logic [A-1:0]          rd_add_b,
   output logic                  mac_clr,
   output logic                  mac_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

`ifdef FIR_SEQ_PREADD_EN
   localparam int unsigned KW      = C;
   localparam int unsigned RUN_LEN = N_TAPS / 2;
`else
   localparam int unsigned KW      = A;
   localparam int unsigned RUN_LEN = N_TAPS;
`endif

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [A-1:0]    base_q, base_d;
   logic [C-1:0]    coef_d;
   logic [A-1:0]    ra_d, rb_d;
   logic            accept;

   assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   // Next state, counter and the read addresses presented during the next RUN cycle
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      base_d  = base_q;
      coef_d  = coef_add;
      ra_d    = rd_add_a;
      rb_d    = rd_add_b;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = RUN;
               k_d     = '0;
               base_d  = wr_ptr;
            end
         end
         RUN: begin
            k_d = k_q + KW'(1);
            if (k_q == KW'(RUN_LEN - 1)) state_d = DRAIN;
         end
         DRAIN: state_d = DONE;
         DONE: begin
            if (out_ready) begin
               if (accept) begin
                  state_d = RUN;
                  k_d     = '0;
                  base_d  = wr_ptr;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d == RUN) begin
         ra_d = base_d - A'(k_d);
`ifdef FIR_SEQ_PREADD_EN
         coef_d = k_d;
         rb_d   = base_d + A'(1) + A'(k_d);
`else
         // Coefficients are symmetric, so the second half walks the ROM backwards
         if (k_d < KW'(N_TAPS / 2)) coef_d = C'(k_d);
         else                       coef_d = C'(KW'(N_TAPS - 1) - k_d);
         rb_d = '0;
`endif
      end
   end

   // State and registered outputs; wr_ptr advances while we is high so it shows the write address
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= IDLE;
         k_q        <= '0;
         base_q     <= '0;
         wr_ptr     <= '0;
         we         <= 1'b0;
         sample_out <= '0;
         coef_add   <= '0;
         rd_add_a   <= '0;
         rd_add_b   <= '0;
         mac_clr    <= 1'b0;
         mac_en     <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         base_q    <= base_d;
         we        <= accept;
         if (accept) sample_out <= sample_in;
         if (we)     wr_ptr     <= wr_ptr + A'(1);
         coef_add  <= coef_d;
         rd_add_a  <= ra_d;
         rd_add_b  <= rb_d;
         mac_en    <= (state_q == RUN);
         mac_clr   <= (state_q == RUN) && (k_q == '0);
         out_valid <= (state_d == DONE);
         busy      <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_fir_seq.sv
// Directed bench for fir_seq: reset, single frame, wrap-around, backpressure, mid-run reset.
module tb_fir_seq;

`ifdef FIR_SEQ_PREADD_EN
   localparam bit PRE  = 1'b1;
   localparam int NRUN = 8;
`else
   localparam bit PRE  = 1'b0;
   localparam int NRUN = 16;
`endif

   logic       clk = 1'b0;
   logic       clr;
   logic       in_valid;
   logic [7:0] sample_in;
   logic       in_ready;
   logic       we;
   logic [3:0] wr_ptr;
   logic [7:0] sample_out;
   logic [2:0] coef_add;
   logic [3:0] rd_add_a;
   logic [3:0] rd_add_b;
   logic       mac_clr;
   logic       mac_en;
   logic       out_valid;
   logic       out_ready;
   logic       busy;

   int nvec = 0;
   int nerr = 0;

   fir_seq #(.WIDTH_DATA(8), .N_TAPS(16)) dut (
      .clk(clk), .clr(clr), .in_valid(in_valid), .sample_in(sample_in),
      .in_ready(in_ready), .we(we), .wr_ptr(wr_ptr), .sample_out(sample_out),
      .coef_add(coef_add), .rd_add_a(rd_add_a), .rd_add_b(rd_add_b),
      .mac_clr(mac_clr), .mac_en(mac_en), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_coef(input int k);
      if (PRE || k < 8) return 32'(k);
      return 32'(15 - k);
   endfunction

   function automatic logic [31:0] exp_ra(input int base, input int k);
      return 32'((base - k) & 15);
   endfunction

   function automatic logic [31:0] exp_rb(input int base, input int k);
      if (!PRE) return 32'd0;
      return 32'((base + 1 + k) & 15);
   endfunction

   // Expects in_valid already high in an accepting cycle; returns one cycle into DONE
   task automatic frame(input logic [7:0] s, input int wa);
      int men;
      men = 0;
      step();
      in_valid = 1'b0;
      chk("e0_we", 32'(we), 32'd1);
      chk("e0_wr_ptr", 32'(wr_ptr), 32'(wa));
      chk("e0_sample_out", 32'(sample_out), 32'(s));
      chk("e0_coef", 32'(coef_add), exp_coef(0));
      chk("e0_rd_a", 32'(rd_add_a), exp_ra(wa, 0));
      chk("e0_rd_b", 32'(rd_add_b), exp_rb(wa, 0));
      chk("e0_mac_en", 32'(mac_en), 32'd0);
      chk("e0_busy", 32'(busy), 32'd1);
      chk("e0_in_ready", 32'(in_ready), 32'd0);
      for (int j = 1; j < NRUN; j++) begin
         step();
         chk("run_coef", 32'(coef_add), exp_coef(j));
         chk("run_rd_a", 32'(rd_add_a), exp_ra(wa, j));
         chk("run_rd_b", 32'(rd_add_b), exp_rb(wa, j));
         chk("run_mac_en", 32'(mac_en), 32'd1);
         chk("run_mac_clr", 32'(mac_clr), (j == 1) ? 32'd1 : 32'd0);
         chk("run_we", 32'(we), 32'd0);
         chk("run_wr_ptr", 32'(wr_ptr), 32'((wa + 1) & 15));
         chk("run_out_valid", 32'(out_valid), 32'd0);
         men += int'(mac_en);
      end
      step();
      men += int'(mac_en);
      chk("drain_mac_en", 32'(mac_en), 32'd1);
      chk("drain_mac_clr", 32'(mac_clr), 32'd0);
      chk("drain_coef_hold", 32'(coef_add), exp_coef(NRUN - 1));
      chk("drain_rd_a_hold", 32'(rd_add_a), exp_ra(wa, NRUN - 1));
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      step();
      chk("done_out_valid", 32'(out_valid), 32'd1);
      chk("done_mac_en", 32'(mac_en), 32'd0);
      chk("done_busy", 32'(busy), 32'd1);
      chk("mac_en_count", 32'(men), 32'(NRUN));
   endtask

   initial begin
      clr = 1'b0; in_valid = 1'b0; sample_in = 8'h00; out_ready = 1'b0;
      repeat (3) step();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
      chk("rst_sample_out", 32'(sample_out), 32'd0);
      chk("rst_coef", 32'(coef_add), 32'd0);
      chk("rst_rd_a", 32'(rd_add_a), 32'd0);
      chk("rst_rd_b", 32'(rd_add_b), 32'd0);
      chk("rst_mac_clr", 32'(mac_clr), 32'd0);
      chk("rst_mac_en", 32'(mac_en), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      clr = 1'b1;
      step();

      // single sample with consumer always ready
      out_ready = 1'b1; in_valid = 1'b1; sample_in = 8'h05;
      #1 chk("idle_in_ready", 32'(in_ready), 32'd1);
      frame(8'h05, 0);
      chk("done_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // sixteen more frames; the last one wraps the write pointer to 0
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b1; sample_in = 8'(i + 8'h10);
         frame(8'(i + 8'h10), i & 15);
         step();
      end

      // backpressure in DONE with a pending sample
      out_ready = 1'b0; in_valid = 1'b1; sample_in = 8'h5A;
      frame(8'h5A, 1);
      in_valid = 1'b1; sample_in = 8'hC3;
      repeat (5) begin
         step();
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_we", 32'(we), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      frame(8'hC3, 2);
      step();
      chk("bp_idle_busy", 32'(busy), 32'd0);

      // reset in the middle of RUN at k=4
      in_valid = 1'b1; sample_in = 8'h77;
      step();
      in_valid = 1'b0;
      chk("mr_wr_ptr", 32'(wr_ptr), 32'd3);
      repeat (4) step();
      chk("mr_mac_en_k4", 32'(mac_en), 32'd1);
      chk("mr_coef_k4", 32'(coef_add), exp_coef(4));
      #2 clr = 1'b0;
      #1;
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_mac_en", 32'(mac_en), 32'd0);
      chk("mr_out_valid", 32'(out_valid), 32'd0);
      chk("mr_wr_ptr_rst", 32'(wr_ptr), 32'd0);
      chk("mr_in_ready", 32'(in_ready), 32'd1);
      step();
      clr = 1'b1;
      repeat (20) begin
         step();
         chk("mr_no_out_valid", 32'(out_valid), 32'd0);
         chk("mr_no_mac_en", 32'(mac_en), 32'd0);
      end

      // normal frame after the abort starts again at address 0
      in_valid = 1'b1; sample_in = 8'h99;
      frame(8'h99, 0);
      step();
      chk("end_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
